// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch stage.
//   fetch_state_t : FSM encoding (IDLE=0, LOAD=1, RUN=2, HALT=3)
//   INSTR_BYTES   : byte stride between consecutive instructions
`ifndef WORD
`define WORD [63:0]
`endif
`ifndef INSTR_LEN
`define INSTR_LEN [31:0]
`endif

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/instr_mem.sv
// instr_mem: loadable instruction memory.
//   clk_i   : write clock
//   we_i    : write enable, wdata_i stored at waddr_i on the rising edge
//   waddr_i : write word index
//   wdata_i : instruction word to store
//   raddr_i : read word index
//   rdata_o : combinational read data
`ifndef INSTR_LEN
`define INSTR_LEN [31:0]
`endif

module instr_mem #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic `INSTR_LEN   wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic `INSTR_LEN   rdata_o
);

    logic `INSTR_LEN mem_q [IMEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage for the LEGv8 datapath.
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   load_en/addr/data  : program-load write port (ignored while running)
//   load_done          : ends program load
//   start              : run from PC 0 (needs a loaded program)
//   stall              : hold pc/instruction
//   pc_src, branch_target : branch redirect from execute
//   pc, instruction, instr_valid : registered fetch outputs
//   halted, fault, state : status / debug
`ifndef WORD
`define WORD [63:0]
`endif
`ifndef INSTR_LEN
`define INSTR_LEN [31:0]
`endif

module instr_fetch
    import fetch_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic `INSTR_LEN   load_data,
    input  logic              load_done,
    input  logic              start,
    input  logic              stall,
    input  logic              pc_src,
    input  logic `WORD        branch_target,
    output logic `WORD        pc,
    output logic `INSTR_LEN   instruction,
    output logic              instr_valid,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        state
);

    localparam int LEN_W = ADDR_W + 1;

    fetch_state_t      state_q;
    logic `WORD        pc_q;
    logic `INSTR_LEN   instr_q;
    logic              valid_q;
    logic              halted_q;
    logic              fault_q;
    logic [LEN_W-1:0]  prog_len_q;

    logic `WORD        next_pc_d;
    logic              misaligned;
    logic              out_of_range;
    logic              mem_we;
    logic [LEN_W-1:0]  load_len;
    logic [ADDR_W-1:0] rd_idx;
    logic `INSTR_LEN   rd_data;

    always_comb begin
        next_pc_d    = pc_src ? branch_target : pc_q + 64'(INSTR_BYTES);
        misaligned   = (next_pc_d[1:0] != 2'b00);
        out_of_range = (next_pc_d[63:2] >= 62'(prog_len_q));
        mem_we       = load_en && (state_q != RUN);
        load_len     = LEN_W'(load_addr) + LEN_W'(1);
        // Outside RUN the only fetch that can happen is the restart at PC 0.
        rd_idx       = (state_q == RUN) ? next_pc_d[ADDR_W+1:2] : '0;
    end

    instr_mem #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_imem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            prog_len_q <= '0;
        end else begin
            if (mem_we && (load_len > prog_len_q)) begin
                prog_len_q <= load_len;
            end

            case (state_q)
                IDLE: begin
                    if (load_en) begin
                        state_q <= load_done ? IDLE : LOAD;
                    end else if (start && (prog_len_q != '0)) begin
                        state_q <= RUN;
                        pc_q    <= '0;
                        instr_q <= rd_data;
                        valid_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_done) begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (misaligned || out_of_range) begin
                            state_q  <= HALT;
                            instr_q  <= '0;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                            fault_q  <= misaligned;
                        end else begin
                            pc_q    <= next_pc_d;
                            instr_q <= rd_data;
                        end
                    end
                end
                HALT: begin
                    if (load_en) begin
                        state_q  <= load_done ? IDLE : LOAD;
                        halted_q <= 1'b0;
                        fault_q  <= 1'b0;
                    end else if (start) begin
                        state_q  <= RUN;
                        pc_q     <= '0;
                        instr_q  <= rd_data;
                        valid_q  <= 1'b1;
                        halted_q <= 1'b0;
                        fault_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign state       = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch. Stimulus pushes the
// expected fetch/halt event; a negedge monitor pops and compares whenever
// the DUT shows a valid fetch or a fresh halt.
module tb_instr_fetch;

    localparam int ADDR_W = 6;

    localparam logic [31:0] W0  = 32'hF84402C9;  // LDUR
    localparam logic [31:0] W1  = 32'h8B090A6A;  // ADD
    localparam logic [31:0] W2  = 32'hCB0A0129;  // SUB
    localparam logic [31:0] W3  = 32'hF80402C9;  // STUR
    localparam logic [31:0] NOP = 32'hD503201F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [31:0]       load_data = '0;
    logic              load_done = 1'b0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic              pc_src = 1'b0;
    logic [63:0]       branch_target = '0;
    logic [63:0]       pc;
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              halted;
    logic              fault;
    logic [1:0]        state;

    instr_fetch #(.IMEM_DEPTH(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .load_done     (load_done),
        .start         (start),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .pc            (pc),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .fault         (fault),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_halt;
        logic [63:0] pc;
        logic [31:0] ins;
        bit          flt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic halted_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_valid(input logic [63:0] p, input logic [31:0] i);
        exp_t e;
        e.is_halt = 1'b0; e.pc = p; e.ins = i; e.flt = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_halt(input logic [63:0] p, input bit f);
        exp_t e;
        e.is_halt = 1'b1; e.pc = p; e.ins = '0; e.flt = f;
        exp_q.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_valid || (halted && !halted_prev)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: pc=0x%0h valid=%0b halted=%0b, nothing expected at %0t",
                             pc, instr_valid, halted, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("event_kind", {63'd0, halted}, {63'd0, e.is_halt});
                    chk("pc", pc, e.pc);
                    chk("instruction", {32'd0, instruction}, {32'd0, e.ins});
                    chk("fault", {63'd0, fault}, {63'd0, e.flt});
                    if (e.is_halt) begin
                        chk("halt_valid", {63'd0, instr_valid}, 64'd0);
                        chk("halt_state", {62'd0, state}, 64'd3);
                    end
                end
            end
        end
        halted_prev = halted;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prog [4];
        prog[0] = W0; prog[1] = W1; prog[2] = W2; prog[3] = W3;

        // Reset values
        step();
        chk("rst_pc", pc, 64'd0);
        chk("rst_instr", {32'd0, instruction}, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_state", {62'd0, state}, 64'd0);
        rst_n = 1'b1;
        step();

        // start with empty program is ignored
        start = 1'b1; step(); start = 1'b0;
        chk("empty_start_state", {62'd0, state}, 64'd0);
        chk("empty_start_valid", {63'd0, instr_valid}, 64'd0);

        // Program load
        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1; load_addr = ADDR_W'(i); load_data = prog[i];
            step();
            chk("load_state", {62'd0, state}, 64'd1);
        end
        load_en = 1'b0; load_done = 1'b1; start = 1'b1;  // start ignored in LOAD
        step();
        load_done = 1'b0; start = 1'b0;
        chk("after_load_state", {62'd0, state}, 64'd0);

        // Sequential run to the end of the program
        start = 1'b1; push_valid(64'd0, W0); step(); start = 1'b0;
        push_valid(64'd4, W1); step();
        push_valid(64'd8, W2); step();
        push_valid(64'd12, W3); step();
        push_halt(64'd12, 1'b0); step();
        chk("seq_halted", {63'd0, halted}, 64'd1);

        // Branches from HALT restart
        start = 1'b1; push_valid(64'd0, W0); step(); start = 1'b0;
        push_valid(64'd4, W1); step();
        pc_src = 1'b1; branch_target = 64'd0; push_valid(64'd0, W0); step();
        branch_target = 64'd8; push_valid(64'd8, W2); step();

        // Stall with a pending redirect
        stall = 1'b1; branch_target = 64'd0;
        for (int i = 0; i < 3; i++) begin
            push_valid(64'd8, W2); step();
        end
        stall = 1'b0; push_valid(64'd0, W0); step();

        // Misaligned target
        branch_target = 64'd6; push_halt(64'd0, 1'b1); step();
        pc_src = 1'b0;
        chk("misalign_fault", {63'd0, fault}, 64'd1);
        start = 1'b1; push_valid(64'd0, W0); step(); start = 1'b0;
        chk("restart_fault", {63'd0, fault}, 64'd0);
        chk("restart_halted", {63'd0, halted}, 64'd0);

        // Out-of-range targets
        pc_src = 1'b1; branch_target = 64'h100; push_halt(64'd0, 1'b0); step();
        pc_src = 1'b0;
        start = 1'b1; push_valid(64'd0, W0); step(); start = 1'b0;
        pc_src = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC; push_halt(64'd0, 1'b0); step();
        pc_src = 1'b0;
        chk("wrap_state", {62'd0, state}, 64'd3);

        // Reset during RUN at pc=8
        start = 1'b1; push_valid(64'd0, W0); step(); start = 1'b0;
        push_valid(64'd4, W1); step();
        push_valid(64'd8, W2); step();
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        chk("midrst_pc", pc, 64'd0);
        chk("midrst_valid", {63'd0, instr_valid}, 64'd0);
        chk("midrst_instr", {32'd0, instruction}, 64'd0);
        chk("midrst_state", {62'd0, state}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        chk("postrst_start_state", {62'd0, state}, 64'd0);
        chk("postrst_start_valid", {63'd0, instr_valid}, 64'd0);

        // load_en + load_done together
        load_en = 1'b1; load_done = 1'b1; load_addr = '0; load_data = NOP;
        step();
        load_en = 1'b0; load_done = 1'b0;
        chk("single_load_state", {62'd0, state}, 64'd0);
        start = 1'b1; push_valid(64'd0, NOP); step(); start = 1'b0;
        push_halt(64'd0, 1'b0); step();

        repeat (3) step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
